data_mem_lsu: RTL and testbench

//  Load/store sequencer between the core pipeline and the word-wide data memory (1-cycle registered read, no byte enables).

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/data_mem_lsu_if.sv | 34 +++
 rtl/lsu_data_align.sv | 56 +++++
 rtl/data_mem_lsu.sv | 131 +++++++++++++
 tb/tb_data_mem_lsu.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - load/store size codes, LSU state type and access-legality helpers
package riscv_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      RD_WAIT,
      WR
   } lsu_state_t;

   // Stores carry no extension, so size[2] is ignored there and only code 3 is illegal.
   function automatic logic size_illegal(input logic we, input logic [2:0] size);
      logic bad;
      if (we) begin
         bad = (size[1:0] == 2'd3);
      end else begin
         bad = !(size inside {LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU});
      end
      return bad;
   endfunction

   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size[1:0])
         2'd1:    mis = addr_lo[0];
         2'd2:    mis = (addr_lo != 2'd0);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// rtl/data_mem_lsu_if.sv - core-side and memory-side signal bundle of the load/store unit
interface data_mem_lsu_if;

   logic        core_req;
   logic        core_we;
   logic [2:0]  core_size;
   logic [31:0] core_addr;
   logic [31:0] core_wd;
   logic [31:0] core_rd;
   logic        core_done;
   logic        core_misalign;
   logic        core_access_fault;
   logic        core_stall;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   // master: the core pipeline together with the data memory
   modport master (
      output core_req, core_we, core_size, core_addr, core_wd, mem_rd,
      input  core_rd, core_done, core_misalign, core_access_fault, core_stall,
      input  mem_req, mem_we, mem_addr, mem_wd
   );

   modport slave (
      input  core_req, core_we, core_size, core_addr, core_wd, mem_rd,
      output core_rd, core_done, core_misalign, core_access_fault, core_stall,
      output mem_req, mem_we, mem_addr, mem_wd
   );

endinterface

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - sub-word load extraction/extension and store lane merge
module lsu_data_align
   import riscv_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (size)
         LDST_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
         LDST_H:  load_data = {{16{half_sel[15]}}, half_sel};
         LDST_BU: load_data = {24'd0, byte_sel};
         LDST_HU: load_data = {16'd0, half_sel};
         default: load_data = rdata;
      endcase
   end

   // Lanes not addressed keep the word just read back from memory.
   always_comb begin
      store_word = rdata;
      case (size[1:0])
         2'd0: begin
            case (addr_lo)
               2'd0:    store_word[7:0]   = wdata[7:0];
               2'd1:    store_word[15:8]  = wdata[7:0];
               2'd2:    store_word[23:16] = wdata[7:0];
               default: store_word[31:24] = wdata[7:0];
            endcase
         end
         2'd1: begin
            if (addr_lo[1]) store_word[31:16] = wdata[15:0];
            else            store_word[15:0]  = wdata[15:0];
         end
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - load/store sequencer between core and word-wide data memory
module data_mem_lsu
   import riscv_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 16384
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   data_mem_lsu_if.slave bus
);

   lsu_state_t  state, state_n;

   logic        lat_we;
   logic [2:0]  lat_size;
   logic [31:0] lat_addr;
   logic [31:0] lat_wd;
   logic [31:0] wr_word;
   logic [31:0] rd_q;
   logic        done_q;
   logic        misalign_q;
   logic        fault_q;

   logic        accept;
   logic        bad_size;
   logic        mis_raw;
   logic        out_range;
   logic        flag_mis;
   logic        flag_fault;
   logic        bad;
   logic        word_store;

   logic [31:0] load_data;
   logic [31:0] store_word;

   // A completion pulse blocks acceptance so a held request is not taken twice.
   assign accept     = (state == IDLE) && bus.core_req && !done_q;
   assign bad_size   = size_illegal(bus.core_we, bus.core_size);
   assign mis_raw    = misaligned(bus.core_size, bus.core_addr[1:0]);
   assign out_range  = (bus.core_addr >= MEM_BYTES);
   assign flag_fault = bad_size || (!mis_raw && out_range);
   assign flag_mis   = !bad_size && mis_raw;
   assign bad        = bad_size || mis_raw || out_range;
   assign word_store = bus.core_we && (bus.core_size[1:0] == 2'd2);

   lsu_data_align u_align (
      .size       (lat_size),
      .addr_lo    (lat_addr[1:0]),
      .rdata      (bus.mem_rd),
      .wdata      (lat_wd),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (accept && !bad) state_n = word_store ? WR : RD;
         end
         RD:      state_n = RD_WAIT;
         RD_WAIT: state_n = lat_we ? WR : IDLE;
         WR:      state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req  = (state == RD) || (state == WR);
      bus.mem_we   = (state == WR);
      bus.mem_addr = {lat_addr[31:2], 2'b00};
      bus.mem_wd   = wr_word;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lat_we     <= 1'b0;
         lat_size   <= 3'd0;
         lat_addr   <= 32'd0;
         lat_wd     <= 32'd0;
         wr_word    <= 32'd0;
         rd_q       <= 32'd0;
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         fault_q    <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_we   <= bus.core_we;
                  lat_size <= bus.core_size;
                  lat_addr <= bus.core_addr;
                  lat_wd   <= bus.core_wd;
                  if (bad) begin
                     done_q     <= 1'b1;
                     misalign_q <= flag_mis;
                     fault_q    <= flag_fault;
                  end else if (word_store) begin
                     wr_word <= bus.core_wd;
                  end
               end
            end
            RD_WAIT: begin
               if (lat_we) begin
                  wr_word <= store_word;
               end else begin
                  rd_q   <= load_data;
                  done_q <= 1'b1;
               end
            end
            WR:      done_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.core_rd           = rd_q;
   assign bus.core_done         = done_q;
   assign bus.core_misalign     = misalign_q;
   assign bus.core_access_fault = fault_q;
   assign bus.core_stall        = bus.core_req && !done_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - directed self-checking bench for data_mem_lsu
module tb_data_mem_lsu;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_lsu_if bus ();

   data_mem_lsu #(.MEM_BYTES(16384)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   logic [31:0] mem [0:4095];
   int          n_rd = 0;
   int          n_wr = 0;
   int          n_done = 0;
   logic [31:0] last_wr_addr = 32'd0;

   always @(posedge clk) begin
      if (bus.mem_req) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr[13:2]] <= bus.mem_wd;
            n_wr <= n_wr + 1;
            last_wr_addr <= bus.mem_addr;
         end else begin
            bus.mem_rd <= mem[bus.mem_addr[13:2]];
            n_rd <= n_rd + 1;
         end
      end
      if (bus.core_done) n_done <= n_done + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   int          r_lat;
   logic [31:0] r_rd;
   logic        r_mis;
   logic        r_flt;
   int          r_nrd;
   int          r_nwr;

   task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input bit keep);
      int rd0;
      int wr0;
      int n;
      rd0 = n_rd;
      wr0 = n_wr;
      bus.core_req  = 1'b1;
      bus.core_we   = we;
      bus.core_size = size;
      bus.core_addr = addr;
      bus.core_wd   = wd;
      #1;
      check_eq("stall_req", {31'd0, bus.core_stall}, 32'd1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.core_done && n < 20);
      if (!bus.core_done) check_eq("timeout", 32'd0, 32'd1);
      r_lat = n;
      r_rd  = bus.core_rd;
      r_mis = bus.core_misalign;
      r_flt = bus.core_access_fault;
      check_eq("stall_at_done", {31'd0, bus.core_stall}, 32'd0);
      if (!keep) bus.core_req = 1'b0;
      @(posedge clk);
      #1;
      check_eq("done_pulse", {29'd0, bus.core_done, bus.core_misalign, bus.core_access_fault}, 32'd0);
      r_nrd = n_rd - rd0;
      r_nwr = n_wr - wr0;
      @(negedge clk);
   endtask

   task automatic load_chk(input string tag, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] exp);
      access(1'b0, size, addr, 32'd0, 1'b0);
      check_eq({tag, "_rd"}, r_rd, exp);
      check_eq({tag, "_lat"}, r_lat, 32'd3);
      check_eq({tag, "_nrd"}, r_nrd, 32'd1);
      check_eq({tag, "_nwr"}, r_nwr, 32'd0);
      check_eq({tag, "_flags"}, {30'd0, r_mis, r_flt}, 32'd0);
   endtask

   task automatic fault_chk(input string tag, input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic exp_mis, input logic exp_flt);
      logic [31:0] rd_before;
      rd_before = bus.core_rd;
      access(we, size, addr, 32'hDEAD_BEEF, 1'b0);
      check_eq({tag, "_lat"}, r_lat, 32'd1);
      check_eq({tag, "_flags"}, {30'd0, r_mis, r_flt}, {30'd0, exp_mis, exp_flt});
      check_eq({tag, "_memreq"}, r_nrd + r_nwr, 32'd0);
      check_eq({tag, "_rd_kept"}, r_rd, rd_before);
   endtask

   initial begin
      int wr0;
      int d0;
      bus.core_req  = 1'b0;
      bus.core_we   = 1'b0;
      bus.core_size = 3'd0;
      bus.core_addr = 32'd0;
      bus.core_wd   = 32'd0;
      for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
      mem[12'h040] = 32'h8899_AABB;
      mem[12'hFFF] = 32'h1357_9BDF;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rd", bus.core_rd, 32'd0);
      check_eq("rst_done_flags", {29'd0, bus.core_done, bus.core_misalign, bus.core_access_fault}, 32'd0);
      check_eq("rst_mem_req_we", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
      check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
      check_eq("rst_mem_wd", bus.mem_wd, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      load_chk("lb_102", LDST_B, 32'h102, 32'hFFFF_FF99);
      load_chk("lbu_102", LDST_BU, 32'h102, 32'h0000_0099);
      load_chk("lh_102", LDST_H, 32'h102, 32'hFFFF_8899);
      load_chk("lhu_100", LDST_HU, 32'h100, 32'h0000_AABB);
      load_chk("lw_100", LDST_W, 32'h100, 32'h8899_AABB);
      load_chk("lb_103", LDST_B, 32'h103, 32'hFFFF_FF88);
      load_chk("lh_100", LDST_H, 32'h100, 32'hFFFF_AABB);
      load_chk("lbu_101", LDST_BU, 32'h101, 32'h0000_00AA);
      load_chk("lw_3ffc", LDST_W, 32'h3FFC, 32'h1357_9BDF);

      access(1'b1, LDST_B, 32'h101, 32'h1234_5677, 1'b0);
      check_eq("sb_lat", r_lat, 32'd4);
      check_eq("sb_nrd", r_nrd, 32'd1);
      check_eq("sb_nwr", r_nwr, 32'd1);
      check_eq("sb_wr_addr", last_wr_addr, 32'h100);
      check_eq("sb_word", mem[12'h040], 32'h8899_77BB);
      check_eq("sb_neighbour", mem[12'h041], 32'd0);
      check_eq("sb_rd_kept", r_rd, 32'h1357_9BDF);

      access(1'b1, LDST_H, 32'h102, 32'hABCD_1234, 1'b0);
      check_eq("sh_lat", r_lat, 32'd4);
      check_eq("sh_word", mem[12'h040], 32'h1234_77BB);

      access(1'b1, LDST_W, 32'h200, 32'hCAFE_F00D, 1'b0);
      check_eq("sw_lat", r_lat, 32'd2);
      check_eq("sw_nrd", r_nrd, 32'd0);
      check_eq("sw_nwr", r_nwr, 32'd1);
      check_eq("sw_word", mem[12'h080], 32'hCAFE_F00D);
      check_eq("sw_rd_kept", r_rd, 32'h1357_9BDF);
      load_chk("lw_200", LDST_W, 32'h200, 32'hCAFE_F00D);

      access(1'b1, LDST_BU, 32'h203, 32'h0000_0055, 1'b0);
      check_eq("sbu_lat", r_lat, 32'd4);
      check_eq("sbu_word", mem[12'h080], 32'h55FE_F00D);

      fault_chk("lw_102", 1'b0, LDST_W, 32'h102, 1'b1, 1'b0);
      fault_chk("lw_4000", 1'b0, LDST_W, 32'h4000, 1'b0, 1'b1);
      fault_chk("lh_101", 1'b0, LDST_H, 32'h101, 1'b1, 1'b0);
      fault_chk("lhu_103", 1'b0, LDST_HU, 32'h103, 1'b1, 1'b0);
      fault_chk("ld_sz3", 1'b0, 3'd3, 32'h100, 1'b0, 1'b1);
      fault_chk("ld_sz6", 1'b0, 3'd6, 32'h100, 1'b0, 1'b1);
      fault_chk("ld_sz3_mis", 1'b0, 3'd3, 32'h101, 1'b0, 1'b1);
      fault_chk("lw_4002", 1'b0, LDST_W, 32'h4002, 1'b1, 1'b0);
      fault_chk("sb_4000", 1'b1, LDST_B, 32'h4000, 1'b0, 1'b1);
      fault_chk("st_sz3", 1'b1, 3'd3, 32'h100, 1'b0, 1'b1);
      fault_chk("st_sz7", 1'b1, 3'd7, 32'h100, 1'b0, 1'b1);
      fault_chk("sh_4001", 1'b1, LDST_H, 32'h4001, 1'b1, 1'b0);
      check_eq("faults_mem_kept", mem[12'h040], 32'h1234_77BB);

      bus.core_req  = 1'b1;
      bus.core_we   = 1'b1;
      bus.core_size = LDST_H;
      bus.core_addr = 32'h100;
      bus.core_wd   = 32'h0000_BEEF;
      @(posedge clk);
      @(posedge clk);
      #1;
      wr0 = n_wr;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_memreq", {31'd0, bus.mem_req}, 32'd0);
      check_eq("rst_mid_rd", bus.core_rd, 32'd0);
      bus.core_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_mid_nwr", n_wr - wr0, 32'd0);
      check_eq("rst_mid_mem", mem[12'h040], 32'h1234_77BB);
      @(negedge clk);

      d0 = n_done;
      access(1'b0, LDST_W, 32'h100, 32'd0, 1'b1);
      check_eq("b2b_lw1_rd", r_rd, 32'h1234_77BB);
      check_eq("b2b_lw1_lat", r_lat, 32'd3);
      access(1'b1, LDST_W, 32'h104, 32'h0BAD_CAFE, 1'b1);
      check_eq("b2b_sw_lat", r_lat, 32'd2);
      check_eq("b2b_sw_nwr", r_nwr, 32'd1);
      access(1'b0, LDST_W, 32'h104, 32'd0, 1'b0);
      check_eq("b2b_lw2_rd", r_rd, 32'h0BAD_CAFE);
      check_eq("b2b_lw2_lat", r_lat, 32'd3);
      check_eq("b2b_done_cnt", n_done - d0, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
